// File: rtl/gtype.sv
// Shared RX PCS types: sync header codes and the link-controller state enum.
package gtype;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        DOWN   = 2'd0,
        SETTLE = 2'd1,
        UP     = 2'd2,
        HIBER  = 2'd3
    } pcs_rx_link_state_t;

    // Only 01 (data) and 10 (control) are legal sync headers.
    function automatic logic hdr_is_valid(input logic [1:0] h);
        return (h == SH_DATA) || (h == SH_CTRL);
    endfunction

endpackage

// File: rtl/ber_mon_rx.sv
// High-BER monitor: counts invalid sync headers per fixed window while locked.
module ber_mon_rx
    import gtype::*;
#(
    parameter int BER_WINDOW = 40283,
    parameter int BER_THRESH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] header,
    input  logic       header_ena,
    input  logic       block_lock,
    output logic       hi_ber
);

    localparam int TW = $clog2(BER_WINDOW) + 1;
    localparam int EW = $clog2(BER_THRESH) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(BER_WINDOW - 1);
    localparam logic [EW-1:0] ERR_MAX    = EW'(BER_THRESH);

    logic [TW-1:0] timer_q, timer_d;
    logic [EW-1:0] err_q, err_d;
    logic          hi_ber_q, hi_ber_d;
    logic          bad_hdr;

    assign bad_hdr = header_ena && !hdr_is_valid(header);

    // Window timer, saturating window error count and the hi_ber flag.
    always_comb begin
        timer_d  = timer_q;
        err_d    = err_q;
        hi_ber_d = hi_ber_q;
        if (!block_lock) begin
            timer_d  = '0;
            err_d    = '0;
            hi_ber_d = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
            // Window boundary: hi_ber only drops if this window stayed below threshold;
            // an invalid header on the wrap cycle opens the next window at 1.
            timer_d = '0;
            if (err_q < ERR_MAX) begin
                hi_ber_d = 1'b0;
            end
            err_d = bad_hdr ? EW'(1) : '0;
            if (err_d == ERR_MAX) begin
                hi_ber_d = 1'b1;
            end
        end else begin
            timer_d = timer_q + TW'(1);
            if (bad_hdr && (err_q < ERR_MAX)) begin
                err_d = err_q + EW'(1);
                if (err_d == ERR_MAX) begin
                    hi_ber_d = 1'b1;
                end
            end
        end
    end

    // Monitor state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            err_q    <= '0;
            hi_ber_q <= 1'b0;
        end else begin
            timer_q  <= timer_d;
            err_q    <= err_d;
            hi_ber_q <= hi_ber_d;
        end
    end

    assign hi_ber = hi_ber_q;

endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// RX PCS link-state controller: sequences decoder reset and link_up from lock and BER status.
module pcs_rx_link_ctrl
    import gtype::*;
#(
    parameter int BER_WINDOW = 40283,
    parameter int BER_THRESH = 16,
    parameter int STABLE_CNT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] header,
    input  logic       header_ena,
    input  logic       block_lock,
    input  logic       ber_cnt_clr,
    output logic       hi_ber,
    output logic       link_up,
    output logic       dec_rst,
    output logic [5:0] ber_count,
    output logic [1:0] state
);

    localparam int SW = $clog2(STABLE_CNT) + 1;
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT - 1);

    pcs_rx_link_state_t state_q, state_d;
    logic [SW-1:0]      stable_q, stable_d;
    logic [5:0]         ber_count_q, ber_count_d;
    logic               dec_rst_q, dec_rst_d;
    logic               link_up_q, link_up_d;
    logic               bad_hdr;
    logic               count_err;

    assign bad_hdr   = header_ena && !hdr_is_valid(header);
    assign count_err = bad_hdr && block_lock;

    ber_mon_rx #(
        .BER_WINDOW(BER_WINDOW),
        .BER_THRESH(BER_THRESH)
    ) u_ber_mon (
        .clk        (clk),
        .rst        (rst),
        .header     (header),
        .header_ena (header_ena),
        .block_lock (block_lock),
        .hi_ber     (hi_ber)
    );

    // Link FSM next state and stable-header run counter; lock loss overrides everything.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        if (!block_lock) begin
            state_d  = DOWN;
            stable_d = '0;
        end else begin
            case (state_q)
                DOWN: begin
                    state_d  = SETTLE;
                    stable_d = '0;
                end
                SETTLE: begin
                    if (hi_ber) begin
                        state_d = HIBER;
                    end else if (header_ena) begin
                        if (!hdr_is_valid(header)) begin
                            stable_d = '0;
                        end else if (stable_q == STABLE_LAST) begin
                            state_d  = UP;
                            stable_d = '0;
                        end else begin
                            stable_d = stable_q + SW'(1);
                        end
                    end
                end
                UP: begin
                    if (hi_ber) begin
                        state_d = HIBER;
                    end
                end
                HIBER: begin
                    if (!hi_ber) begin
                        state_d  = SETTLE;
                        stable_d = '0;
                    end
                end
                default: begin
                    state_d  = DOWN;
                    stable_d = '0;
                end
            endcase
        end
    end

    // Outputs derived from the next state so they line up with the state register.
    always_comb begin
        dec_rst_d = (state_d != UP);
        link_up_d = (state_d == UP);
    end

    // Saturating invalid-header counter; a clear coincident with an error keeps that error.
    always_comb begin
        ber_count_d = ber_count_q;
        if (ber_cnt_clr) begin
            ber_count_d = count_err ? 6'd1 : 6'd0;
        end else if (count_err && (ber_count_q != 6'd63)) begin
            ber_count_d = ber_count_q + 6'd1;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DOWN;
            stable_q    <= '0;
            ber_count_q <= '0;
            dec_rst_q   <= 1'b1;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stable_q    <= stable_d;
            ber_count_q <= ber_count_d;
            dec_rst_q   <= dec_rst_d;
            link_up_q   <= link_up_d;
        end
    end

    assign state     = state_q;
    assign ber_count = ber_count_q;
    assign dec_rst   = dec_rst_q;
    assign link_up   = link_up_q;

endmodule

// File: tb/tb_pcs_rx_link_ctrl.sv
// Directed bench for pcs_rx_link_ctrl with a cycle-level reference model.
module tb_pcs_rx_link_ctrl;

    localparam int W = 100;
    localparam int T = 16;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] header = 2'b00;
    logic       header_ena = 1'b0;
    logic       block_lock = 1'b0;
    logic       ber_cnt_clr = 1'b0;
    logic       hi_ber;
    logic       link_up;
    logic       dec_rst;
    logic [5:0] ber_count;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model (state numbering: 0 DOWN, 1 SETTLE, 2 UP, 3 HIBER)
    int m_tick  = 0;
    int m_werr  = 0;
    int m_hi    = 0;
    int m_bc    = 0;
    int m_state = 0;
    int m_run   = 0;

    pcs_rx_link_ctrl #(
        .BER_WINDOW(W),
        .BER_THRESH(T),
        .STABLE_CNT(S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .header      (header),
        .header_ena  (header_ena),
        .block_lock  (block_lock),
        .ber_cnt_clr (ber_cnt_clr),
        .hi_ber      (hi_ber),
        .link_up     (link_up),
        .dec_rst     (dec_rst),
        .ber_count   (ber_count),
        .state       (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: errors per window as a plain integer, hi_ber from >= threshold tests.
    always @(posedge clk) begin : model
        int inv, inc, nt, nw, nh, nb, ns, nr;
        inv = (header_ena && (header == 2'b00 || header == 2'b11)) ? 1 : 0;
        inc = (inv == 1 && block_lock) ? 1 : 0;
        nt = m_tick; nw = m_werr; nh = m_hi; ns = m_state; nr = m_run;
        if (ber_cnt_clr) nb = inc;
        else nb = (m_bc + inc > 63) ? 63 : m_bc + inc;
        if (rst) begin
            nt = 0; nw = 0; nh = 0; nb = 0; ns = 0; nr = 0;
        end else if (!block_lock) begin
            nt = 0; nw = 0; nh = 0; ns = 0; nr = 0;
        end else begin
            if (m_tick == W - 1) begin
                nt = 0;
                nw = inv;
                nh = (m_werr >= T) ? m_hi : 0;
                if (nw >= T) nh = 1;
            end else begin
                nt = m_tick + 1;
                nw = m_werr + inv;
                nh = (m_hi == 1 || nw >= T) ? 1 : 0;
            end
            case (m_state)
                0: begin ns = 1; nr = 0; end
                1: begin
                    if (m_hi == 1) ns = 3;
                    else if (header_ena) begin
                        if (inv == 1) nr = 0;
                        else begin
                            nr = m_run + 1;
                            if (nr >= S) ns = 2;
                        end
                    end
                end
                2: if (m_hi == 1) ns = 3;
                default: if (m_hi == 0) begin ns = 1; nr = 0; end
            endcase
        end
        m_tick <= nt; m_werr <= nw; m_hi <= nh; m_bc <= nb; m_state <= ns; m_run <= nr;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("hi_ber", int'(hi_ber), m_hi);
            chk("ber_count", int'(ber_count), m_bc);
            chk("link_up", int'(link_up), (m_state == 2) ? 1 : 0);
            chk("dec_rst", int'(dec_rst), (m_state != 2) ? 1 : 0);
        end
    end

    task automatic drive(input logic lk, input logic en, input logic [1:0] h, input logic clr);
        block_lock  = lk;
        header_ena  = en;
        header      = h;
        ber_cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic bring_up();
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < S; i++) drive(1'b1, 1'b1, 2'b01, 1'b0);
    endtask

    initial begin
        // Reset
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        chk_en = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        chk("rst_state", int'(state), 0);
        chk("rst_dec_rst", int'(dec_rst), 1);
        chk("rst_link_up", int'(link_up), 0);
        chk("rst_ber_count", int'(ber_count), 0);

        // Bring-up
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        chk("bringup_settle", int'(state), 1);
        for (int i = 0; i < S; i++) begin
            drive(1'b1, 1'b1, 2'b01, 1'b0);
            if (i == S - 2) chk("bringup_not_early", int'(state), 1);
        end
        chk("bringup_up", int'(state), 2);
        chk("bringup_link_up", int'(link_up), 1);
        chk("bringup_dec_rst", int'(dec_rst), 0);

        // Lock loss from UP
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        chk("lockloss_up_state", int'(state), 0);
        chk("lockloss_up_dec_rst", int'(dec_rst), 1);

        // Settle interruption: 5 valid, one 11, 8 valid
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 2'b10, 1'b0);
        drive(1'b1, 1'b1, 2'b11, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 2'b01, 1'b0);
        chk("interrupt_still_settle", int'(state), 1);
        drive(1'b1, 1'b1, 2'b01, 1'b0);
        chk("interrupt_up_at_14", int'(state), 2);

        // High BER from a fresh window
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        bring_up();
        for (int i = 0; i < T - 1; i++) drive(1'b1, 1'b1, 2'b00, 1'b0);
        chk("hiber_below", int'(hi_ber), 0);
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        chk("hiber_set", int'(hi_ber), 1);
        chk("hiber_state_lag", int'(state), 2);
        drive(1'b1, 1'b0, 2'b00, 1'b0);
        chk("hiber_state", int'(state), 3);
        chk("hiber_dec_rst", int'(dec_rst), 1);
        for (int i = 0; i < 300 && hi_ber; i++) drive(1'b1, 1'b1, 2'b01, 1'b0);
        chk("hiber_clear_timeout", int'(hi_ber), 0);
        chk("hiber_clear_state", int'(state), 3);
        drive(1'b1, 1'b1, 2'b01, 1'b0);
        chk("hiber_to_settle", int'(state), 1);
        for (int i = 0; i < S; i++) drive(1'b1, 1'b1, 2'b01, 1'b0);
        chk("hiber_back_up", int'(state), 2);

        // Below threshold: 15 errors per window for 3 windows
        drive(1'b0, 1'b0, 2'b00, 1'b1);
        bring_up();
        for (int i = 0; i < 3 * W; i++) begin
            if ((i % W) >= 20 && (i % W) < 20 + T - 1) drive(1'b1, 1'b1, 2'b11, 1'b0);
            else drive(1'b1, 1'b1, 2'b10, 1'b0);
        end
        chk("below_ber_count", int'(ber_count), 45);
        chk("below_hi_ber", int'(hi_ber), 0);
        chk("below_state", int'(state), 2);

        // Saturation and clear
        for (int i = 0; i < 70; i++) drive(1'b1, 1'b1, 2'b00, 1'b0);
        chk("sat_ber_count", int'(ber_count), 63);
        drive(1'b1, 1'b0, 2'b00, 1'b1);
        chk("clr_alone", int'(ber_count), 0);
        drive(1'b1, 1'b1, 2'b00, 1'b1);
        chk("clr_with_err", int'(ber_count), 1);
        chk("sat_state_hiber", int'(state), 3);

        // Lock loss from HIBER
        drive(1'b0, 1'b1, 2'b00, 1'b0);
        chk("lockloss_hiber_state", int'(state), 0);
        chk("lockloss_hiber_hi_ber", int'(hi_ber), 0);
        chk("lockloss_hiber_dec_rst", int'(dec_rst), 1);
        chk("lockloss_ber_hold", int'(ber_count), 1);

        // Reset while UP
        bring_up();
        chk("pre_rst_up", int'(state), 2);
        rst = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 1'b0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_link_up", int'(link_up), 0);
        chk("midrst_dec_rst", int'(dec_rst), 1);
        chk("midrst_ber_count", int'(ber_count), 0);
        chk("midrst_hi_ber", int'(hi_ber), 0);
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 2'b00, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
